// File: rtl/bm_quad_step_decoder.sv
// bm_quad_step_decoder
//   Front end for the n-bit up/down counter. Takes raw asynchronous
//   quadrature channels (A, B) and an index channel (Z), synchronises and
//   glitch-filters each one, then decodes Gray-code transitions into
//   single-cycle step pulses with direction plus an index load pulse.
//
// Ports
//   Clock     : system clock, everything on posedge
//   Reset     : synchronous, active-high
//   A, B, Z   : raw encoder / index channels (asynchronous)
//   index_en  : allow L generation from the index channel
//   home_val  : value driven onto R when an index load fires
//   clr_err   : clears err (a simultaneous new error wins)
//   E         : one-cycle step pulse
//   up_down   : direction of last valid step, 1 = up
//   L         : one-cycle index load pulse
//   R         : load value for the counter
//   err       : sticky illegal (double) transition flag

// Per-channel synchroniser + persistence filter.
//   Clock : system clock
//   Reset : synchronous, active-high
//   raw   : asynchronous input
//   filt  : filtered, synchronous version of raw
module bm_qsd_chan #(
    parameter int FILT = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic filt
);
    localparam logic [3:0] CNT_MAX = 4'(FILT - 1);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic [3:0] cnt_q, cnt_d;
    logic       filt_q, filt_d;

    always_comb begin
        s1_d   = raw;
        s2_d   = s1_q;
        cnt_d  = 4'd0;
        filt_d = filt_q;
        // Any cycle of agreement drops cnt back to 0, so only an unbroken
        // run of FILT disagreeing samples moves the filtered value.
        if (s2_q != filt_q) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = s2_q;
                cnt_d  = 4'd0;
            end else begin
                cnt_d  = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= 4'd0;
            filt_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
endmodule

module bm_quad_step_decoder #(
    parameter int n    = 2,
    parameter int FILT = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         A,
    input  logic         B,
    input  logic         Z,
    input  logic         index_en,
    input  logic [n-1:0] home_val,
    input  logic         clr_err,
    output logic         E,
    output logic         up_down,
    output logic         L,
    output logic [n-1:0] R,
    output logic         err
);
    localparam logic [4:0] ARM_CYC = 5'(FILT + 3);

    // bit 2 = A, bit 1 = B, bit 0 = Z
    logic [2:0] raw_in;
    logic [2:0] filt;

    assign raw_in = {A, B, Z};

    for (genvar g = 0; g < 3; g++) begin : g_chan
        bm_qsd_chan #(.FILT(FILT)) u_chan (
            .Clock (Clock),
            .Reset (Reset),
            .raw   (raw_in[g]),
            .filt  (filt[g])
        );
    end

    logic [4:0]   start_cnt_q, start_cnt_d;
    logic [1:0]   ab_prev_q, ab_prev_d;
    logic         z_prev_q, z_prev_d;
    logic         e_q, e_d;
    logic         ud_q, ud_d;
    logic         l_q, l_d;
    logic [n-1:0] r_q, r_d;
    logic         err_q, err_d;

    logic         armed;
    logic [1:0]   cur;
    logic [1:0]   diff;

    assign armed = (start_cnt_q == ARM_CYC);
    assign cur   = filt[2:1];
    assign diff  = cur ^ ab_prev_q;

    always_comb begin
        start_cnt_d = armed ? start_cnt_q : start_cnt_q + 5'd1;
        ab_prev_d   = cur;
        z_prev_d    = filt[0];
        e_d         = 1'b0;
        ud_d        = ud_q;
        l_d         = 1'b0;
        r_d         = r_q;
        err_d       = 1'b0;   // held low while the filters settle after reset
        if (armed) begin
            if (diff == 2'b11) begin
                err_d = 1'b1;
            end else if (clr_err) begin
                err_d = 1'b0;
            end else begin
                err_d = err_q;
            end
            // Single-bit change: in the 00,01,11,10 cycle a forward step
            // always makes the new A equal to the old B.
            if (diff == 2'b01 || diff == 2'b10) begin
                e_d  = 1'b1;
                ud_d = (cur[1] == ab_prev_q[0]);
            end
            if (index_en && filt[0] && !z_prev_q) begin
                l_d = 1'b1;
                r_d = home_val;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            start_cnt_q <= 5'd0;
            ab_prev_q   <= 2'b00;
            z_prev_q    <= 1'b0;
            e_q         <= 1'b0;
            ud_q        <= 1'b1;
            l_q         <= 1'b0;
            r_q         <= '0;
            err_q       <= 1'b0;
        end else begin
            start_cnt_q <= start_cnt_d;
            ab_prev_q   <= ab_prev_d;
            z_prev_q    <= z_prev_d;
            e_q         <= e_d;
            ud_q        <= ud_d;
            l_q         <= l_d;
            r_q         <= r_d;
            err_q       <= err_d;
        end
    end

    assign E       = e_q;
    assign up_down = ud_q;
    assign L       = l_q;
    assign R       = r_q;
    assign err     = err_q;
endmodule

// File: tb/tb_bm_quad_step_decoder.sv
module tb_bm_quad_step_decoder;
    localparam int N    = 2;
    localparam int FILT = 3;
    localparam int MAXC = 4096;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         A = 1'b0, B = 1'b0, Z = 1'b0;
    logic         index_en = 1'b0;
    logic         clr_err = 1'b0;
    logic [N-1:0] home_val = '0;
    logic         E, up_down, L, err;
    logic [N-1:0] R;

    bm_quad_step_decoder #(.n(N), .FILT(FILT)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .Z        (Z),
        .index_en (index_en),
        .home_val (home_val),
        .clr_err  (clr_err),
        .E        (E),
        .up_down  (up_down),
        .L        (L),
        .R        (R),
        .err      (err)
    );

    always #5 Clock = ~Clock;

    int nassert = 0;
    int nfail   = 0;
    int ncyc    = 0;

    // Reference model: raw samples per edge since reset release, and the
    // filtered value those samples imply. Bit 2 = A, 1 = B, 0 = Z.
    int           n = 0;
    bit [2:0]     raw [0:MAXC];
    bit [2:0]     flt [0:MAXC];
    bit           m_e, m_l, m_err, m_ud = 1'b1;
    bit [N-1:0]   m_r;

    int e_cnt, l_cnt, first_e, first_l;
    bit first_ud;

    function automatic int gpos(input bit [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit [1:0] pos2ab(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, ncyc, obs, exp);
        end
    endtask

    task automatic tick();
        bit       all_diff;
        bit       x;
        int       k, d;
        bit [2:0] cur, prv;
        @(posedge Clock);
        ncyc++;
        if (Reset) begin
            n = 0; raw[0] = '0; flt[0] = '0;
            m_e = 0; m_l = 0; m_err = 0; m_ud = 1; m_r = '0;
        end else begin
            n++;
            if (n >= MAXC) begin
                $display("FAIL model_depth: observed %0d required < %0d", n, MAXC);
                $fatal(1, "model history exhausted");
            end
            raw[n] = {A, B, Z};
            // A channel's filtered value flips once its last FILT
            // synchronised samples (two edges old) all disagree with it.
            for (int ch = 0; ch < 3; ch++) begin
                all_diff = 1'b1;
                for (int j = 0; j < FILT; j++) begin
                    k = n - j - 2;
                    x = (k >= 1) ? raw[k][ch] : 1'b0;
                    if (x == flt[n-1][ch]) all_diff = 1'b0;
                end
                flt[n][ch] = all_diff ? ~flt[n-1][ch] : flt[n-1][ch];
            end
            m_e = 0; m_l = 0;
            if (n >= FILT + 4) begin
                cur = flt[n-1];
                prv = flt[n-2];
                d = (gpos(cur[2:1]) - gpos(prv[2:1]) + 4) % 4;
                if (d == 1) begin m_e = 1; m_ud = 1; end
                else if (d == 3) begin m_e = 1; m_ud = 0; end
                if (d == 2) m_err = 1;
                else if (clr_err) m_err = 0;
                if (index_en && cur[0] && !prv[0]) begin
                    m_l = 1; m_r = home_val;
                end
            end else begin
                m_err = 0;
            end
        end
        #1;
        chk("E", 32'(E), 32'(m_e));
        chk("up_down", 32'(up_down), 32'(m_ud));
        chk("L", 32'(L), 32'(m_l));
        chk("R", 32'(R), 32'(m_r));
        chk("err", 32'(err), 32'(m_err));
        if (E === 1'b1) begin
            e_cnt++;
            if (first_e < 0) begin first_e = ncyc; first_ud = up_down; end
        end
        if (L === 1'b1) begin
            l_cnt++;
            if (first_l < 0) first_l = ncyc;
        end
    endtask

    task automatic hold(input bit a, input bit b, input bit z, input int cyc);
        A = a; B = b; Z = z;
        repeat (cyc) tick();
    endtask

    initial begin
        int t0, pos, r, len;
        bit [1:0] ab;

        // reset state
        Reset = 1'b1;
        repeat (3) tick();
        chk("rst_up_down", 32'(up_down), 32'd1);
        Reset = 1'b0;

        // 1: forward sequence
        hold(0, 0, 0, 10);
        e_cnt = 0; first_e = -1; t0 = ncyc;
        hold(0, 1, 0, 8);
        hold(1, 1, 0, 8);
        hold(1, 0, 0, 8);
        hold(0, 0, 0, 8);
        chk("fwd_count", 32'(e_cnt), 32'd4);
        chk("fwd_latency", 32'(first_e - t0), 32'(FILT + 3));
        chk("fwd_dir", 32'(up_down), 32'd1);
        chk("fwd_err", 32'(err), 32'd0);

        // 2: reverse sequence
        e_cnt = 0; first_e = -1;
        hold(1, 0, 0, 8);
        hold(1, 1, 0, 8);
        hold(0, 1, 0, 8);
        hold(0, 0, 0, 8);
        chk("rev_count", 32'(e_cnt), 32'd4);
        chk("rev_first_dir", 32'(first_ud), 32'd0);
        chk("rev_dir", 32'(up_down), 32'd0);

        // 3: glitches; a FILT-long pulse is followed up and back down,
        // so it yields one step out and one step back
        e_cnt = 0;
        hold(1, 0, 0, 2);
        hold(0, 0, 0, 12);
        chk("glitch2_count", 32'(e_cnt), 32'd0);
        hold(1, 0, 0, 3);
        hold(0, 0, 0, 12);
        chk("glitch3_count", 32'(e_cnt), 32'd2);

        // 4: double transitions and clr_err
        e_cnt = 0;
        hold(1, 1, 0, 10);
        chk("dbl_err", 32'(err), 32'd1);
        chk("dbl_no_step", 32'(e_cnt), 32'd0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err", 32'(err), 32'd0);
        hold(0, 0, 0, FILT + 2);
        clr_err = 1'b1; tick(); clr_err = 1'b0;   // coincides with detection
        hold(0, 0, 0, 4);
        chk("set_beats_clr", 32'(err), 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err2", 32'(err), 32'd0);

        // 5: index load
        home_val = 2'b10; index_en = 1'b1;
        l_cnt = 0; first_l = -1; t0 = ncyc;
        hold(0, 0, 1, 10);
        chk("idx_count", 32'(l_cnt), 32'd1);
        chk("idx_latency", 32'(first_l - t0), 32'(FILT + 3));
        chk("idx_R", 32'(R), 32'b10);
        hold(0, 0, 0, 10);
        chk("idx_fall", 32'(l_cnt), 32'd1);
        index_en = 1'b0; home_val = 2'b01;
        hold(0, 0, 1, 10);
        hold(0, 0, 0, 10);
        chk("idx_dis_count", 32'(l_cnt), 32'd1);
        chk("idx_dis_R", 32'(R), 32'b10);

        // 6: reset mid-operation with A=B=1
        hold(1, 0, 0, 8);
        hold(1, 1, 0, 8);
        chk("pre_rst_dir", 32'(up_down), 32'd0);
        Reset = 1'b1;
        hold(1, 1, 0, 2);
        chk("mid_rst_dir", 32'(up_down), 32'd1);
        chk("mid_rst_R", 32'(R), 32'd0);
        Reset = 1'b0;
        e_cnt = 0;
        hold(1, 1, 0, FILT + 3);
        chk("arm_no_step", 32'(e_cnt), 32'd0);
        chk("arm_no_err", 32'(err), 32'd0);
        hold(1, 1, 0, 6);
        chk("armed_quiet", 32'(e_cnt), 32'd0);
        hold(1, 0, 0, 10);
        chk("post_rst_step", 32'(e_cnt), 32'd1);
        chk("post_rst_dir", 32'(up_down), 32'd1);

        // 7: random steps, holds (some short enough to merge), index, clr
        pos = gpos({A, B});
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) pos = (pos + 1) % 4;
            else if (r <= 6) pos = (pos + 3) % 4;
            else if (r == 7) pos = (pos + 2) % 4;
            ab = pos2ab(pos);
            if ($urandom_range(0, 3) == 0) Z = ~Z;
            index_en = 1'($urandom_range(0, 1));
            home_val = N'($urandom_range(0, (1 << N) - 1));
            A = ab[1]; B = ab[0];
            len = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) begin
                clr_err = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        clr_err = 1'b0;
        hold(A, B, Z, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
